// File: rtl/rr_arbiter8_pkg.sv
// rr_arbiter8_pkg: shared sizes and FSM state encodings for the round-robin arbiter
package rr_arbiter8_pkg;
  localparam int ARB_N = 8;
  localparam int ARB_IDX_W = 3;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
endpackage

// File: rtl/rr_arbiter8_dec3to8.sv
// dec3to8: 3-to-8 one-hot decoder with enable, all-zero when disabled
module dec3to8 (
  input  logic [2:0] w,
  input  logic       en,
  output logic [7:0] f
);
  assign f = en ? (8'd1 << w) : 8'h00;
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-requester round-robin arbiter with bounded grant hold time
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 en,
  input  logic [ARB_N-1:0]     req,
  output logic [ARB_N-1:0]     gnt,
  output logic [ARB_IDX_W-1:0] gnt_id,
  output logic                 gnt_valid,
  output logic                 timeout
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_HOLD - 1);
  state_t               state;
  logic [ARB_IDX_W-1:0] ptr;
  logic [ARB_IDX_W-1:0] off;
  logic [ARB_IDX_W-1:0] sel;
  logic [CNT_W-1:0]     cnt;
  logic [2*ARB_N-1:0]   dbl;
  logic [ARB_N-1:0]     rot;
  // Rotating right by ptr puts the highest-priority requester at bit 0.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[ARB_N-1:0];
  always_comb begin
    off = '0;
    for (int i = ARB_N - 1; i >= 0; i--)
      if (rot[i]) off = ARB_IDX_W'(i);
  end
  assign sel = ptr + off;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (state == ST_IDLE) begin
        if (en && |req) begin
          gnt_id    <= sel;
          gnt_valid <= 1'b1;
          cnt       <= '0;
          state     <= ST_GRANT;
        end
      end else if (!req[gnt_id] || cnt == LAST) begin
        // A voluntary drop on the limit edge is a normal release, not a timeout.
        gnt_valid <= 1'b0;
        ptr       <= gnt_id + 1'b1;
        state     <= ST_IDLE;
        timeout   <= req[gnt_id];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
  dec3to8 u_dec (
    .w  (gnt_id),
    .en (gnt_valid),
    .f  (gnt)
  );
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: randomized scoreboard bench against a behavioural round-robin model
module tb_rr_arbiter8;
  localparam int MAX_HOLD = 15;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [7:0] gnt;
    int         id;
    logic       vld;
    logic       to;
  } exp_t;
  exp_t exp_q[$];
  int rst_events = 0;
  int rst_seen = 0;
  int owner = -1;
  int held = 0;
  int mptr = 0;
  logic mto = 1'b0;
  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );
  always #5 clk = ~clk;
  always @(negedge resetn) rst_events++;
  task automatic check(input string name, input int act, input int req_v);
    checks++;
    if (act != req_v) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, req_v, $time);
    end
  endtask
  // Reference model: owner index, cycles held, next search start.
  always @(posedge clk) begin
    exp_t e;
    if (!resetn || rst_seen != rst_events) begin
      owner = -1; held = 0; mptr = 0; mto = 1'b0;
      rst_seen = rst_events;
    end
    if (resetn) begin
      mto = 1'b0;
      if (owner < 0) begin
        if (en && req != 8'h00)
          for (int i = 0; i < 8; i++)
            if (owner < 0 && req[(mptr + i) % 8]) begin
              owner = (mptr + i) % 8;
              held = 1;
            end
      end else if (!req[owner]) begin
        mptr = (owner + 1) % 8; owner = -1;
      end else if (held == MAX_HOLD) begin
        mptr = (owner + 1) % 8; owner = -1; mto = 1'b1;
      end else begin
        held++;
      end
    end
    e.vld = owner >= 0;
    e.id  = owner;
    e.gnt = e.vld ? 8'(1 << owner) : 8'h00;
    e.to  = mto;
    exp_q.push_back(e);
  end
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("queue_empty", 0, 1);
      end else begin
        e = exp_q.pop_front();
        check("gnt", int'(gnt), int'(e.gnt));
        check("gnt_valid", int'(gnt_valid), int'(e.vld));
        check("timeout", int'(timeout), int'(e.to));
        if (e.vld) check("gnt_id", int'(gnt_id), e.id);
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic drive(input logic e_v, input logic [7:0] r);
    @(negedge clk);
    en = e_v;
    req = r;
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    check("async_gnt", int'(gnt), 0);
    check("async_valid", int'(gnt_valid), 0);
    check("async_timeout", int'(timeout), 0);
    #1 resetn = 1'b1;
  endtask
  initial begin
    // Reset with everything requesting
    resetn = 1'b0; en = 1'b1; req = 8'hFF;
    cyc(3);
    check("reset_gnt", int'(gnt), 0);
    check("reset_valid", int'(gnt_valid), 0);
    check("reset_timeout", int'(timeout), 0);
    drive(1'b0, 8'h00);
    resetn = 1'b1;
    drive(1'b1, 8'h08);
    cyc(3);
    drive(1'b1, 8'h00);
    cyc(2);
    // Full contention: every requester times out in turn
    drive(1'b1, 8'hFF);
    cyc(9 * 16 + 2);
    drive(1'b1, 8'h00);
    cyc(2);
    drive(1'b1, 8'h40);
    cyc(3);
    drive(1'b1, 8'h41);
    cyc(40);
    drive(1'b0, 8'h00);
    cyc(2);
    // Enable gating
    drive(1'b0, 8'h01);
    cyc(4);
    drive(1'b1, 8'h01);
    cyc(2);
    drive(1'b0, 8'h01);
    cyc(5);
    drive(1'b0, 8'h00);
    cyc(2);
    drive(1'b0, 8'hFF);
    cyc(4);
    // Reset mid-grant of id 5
    drive(1'b1, 8'h00);
    cyc(2);
    drive(1'b1, 8'h20);
    cyc(3);
    pulse_reset();
    cyc(4);
    drive(1'b1, 8'h00);
    cyc(2);
    // Random traffic with sticky requests
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) req = req ^ (8'd1 << $urandom_range(0, 7));
      if ($urandom_range(0, 63) == 0) req = 8'($urandom);
      if ($urandom_range(0, 499) == 0) pulse_reset();
    end
    drive(1'b0, 8'h00);
    cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
